// File: rtl/example_accum_pkg.sv
// Shared widths, types and saturation-bound helpers for the product
// reduction stages of the GNN datapath.
package example_accum_pkg;
   localparam int DEF_PROD_W  = 21;
   localparam int DEF_ACC_W   = 32;
   localparam int DEF_OUT_W   = 16;
   localparam int DEF_SHIFT   = 8;
   localparam int DEF_MAX_LEN = 1024;

   typedef logic signed [DEF_PROD_W-1:0] prod_t;
   typedef logic signed [DEF_ACC_W-1:0]  acc_t;
   typedef logic signed [DEF_OUT_W-1:0]  out_t;

   typedef enum logic {O_EMPTY, O_FULL} ostate_e;

   // Largest / smallest value representable in a signed field of width w.
   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction
endpackage

// File: rtl/example_round_sat.sv
// Round-half-up arithmetic shift followed by signed saturation to OUT_W.
// The caller supplies at least one headroom bit so the rounding add cannot wrap.
module example_round_sat
   import example_accum_pkg::*;
#(
   parameter int IN_W  = DEF_ACC_W + 1,
   parameter int OUT_W = DEF_OUT_W,
   parameter int SHIFT = DEF_SHIFT
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);
   localparam logic signed [IN_W-1:0] OMAX = IN_W'(sat_max(OUT_W));
   localparam logic signed [IN_W-1:0] OMIN = IN_W'(sat_min(OUT_W));

   logic signed [IN_W-1:0] rnd, shd;

   generate
      if (SHIFT > 0) begin : g_rnd
         localparam logic signed [IN_W-1:0] HALF = IN_W'(64'sd1 <<< (SHIFT - 1));
         assign rnd = din + HALF;
      end else begin : g_nornd
         assign rnd = din;
      end
   endgenerate

   always_comb begin
      shd = rnd >>> SHIFT;
      if (shd > OMAX)      dout = OMAX[OUT_W-1:0];
      else if (shd < OMIN) dout = OMIN[OUT_W-1:0];
      else                 dout = shd[OUT_W-1:0];
   end
endmodule

// File: rtl/example_prod_accum.sv
// Group reduction of signed multiplier products into a saturating accumulator,
// with a one-deep registered valid/ready result slot.
module example_prod_accum
   import example_accum_pkg::*;
#(
   parameter int PROD_W  = DEF_PROD_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int SHIFT   = DEF_SHIFT,
   parameter int MAX_LEN = DEF_MAX_LEN,
   localparam int CNT_W  = $clog2(MAX_LEN) + 1
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic signed [PROD_W-1:0] prod_data,
   input  logic                    prod_valid,
   input  logic                    prod_last,
   output logic                    prod_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        out_beats,
   output logic                    acc_ovf,
   output logic                    len_err
);
   localparam logic signed [ACC_W:0] AMAX = (ACC_W+1)'(sat_max(ACC_W));
   localparam logic signed [ACC_W:0] AMIN = (ACC_W+1)'(sat_min(ACC_W));
   localparam logic [CNT_W-1:0]      CMAX = CNT_W'(MAX_LEN);

   ostate_e                 state, state_nx;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt, cnt_nx;
   logic                    first, take, last_take, out_take, ovf, cnt_sat;
   logic signed [ACC_W:0]   base, sum, sum_c;
   logic signed [OUT_W-1:0] rs_out;

   assign out_valid  = (state == O_FULL);
   // Only a closing beat needs the result slot, so only it can be stalled.
   assign prod_ready = !prod_last || !out_valid || out_ready;
   assign take       = prod_valid && prod_ready;
   assign last_take  = take && prod_last;
   assign out_take   = out_valid && out_ready;

   always_comb begin
      base = '0;
      if (!first) base = (ACC_W+1)'(acc);
      sum   = base + (ACC_W+1)'(prod_data);
      ovf   = (sum > AMAX) || (sum < AMIN);
      sum_c = sum;
      if (sum > AMAX)      sum_c = AMAX;
      else if (sum < AMIN) sum_c = AMIN;
      cnt_sat = !first && (cnt == CMAX);
      if (first)        cnt_nx = CNT_W'(1);
      else if (cnt_sat) cnt_nx = CMAX;
      else              cnt_nx = cnt + CNT_W'(1);
   end

   example_round_sat #(
      .IN_W  (ACC_W + 1),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .din  (sum_c),
      .dout (rs_out)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state <= O_EMPTY;
      else           state <= state_nx;
   end

   // A new result overwrites the slot even while the old one is being taken.
   always_comb begin
      state_nx = state;
      if (last_take)     state_nx = O_FULL;
      else if (out_take) state_nx = O_EMPTY;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         first     <= 1'b1;
         out_data  <= '0;
         out_beats <= '0;
         acc_ovf   <= 1'b0;
         len_err   <= 1'b0;
      end else if (take) begin
         if (ovf)     acc_ovf <= 1'b1;
         if (cnt_sat) len_err <= 1'b1;
         if (prod_last) begin
            first     <= 1'b1;
            cnt       <= '0;
            out_data  <= rs_out;
            out_beats <= cnt_nx;
         end else begin
            acc   <= sum_c[ACC_W-1:0];
            cnt   <= cnt_nx;
            first <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_example_prod_accum.sv
// Directed plus randomized bench for example_prod_accum against a
// transaction-level reference model of the group reduction.
module tb_example_prod_accum;
   import example_accum_pkg::*;

   localparam longint AMAX = 64'sd2147483647;
   localparam longint AMIN = -64'sd2147483648;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   prod_t       prod_data;
   logic        prod_valid, prod_last, prod_ready;
   out_t        out_data;
   logic        out_valid, out_ready, acc_ovf, len_err;
   logic [10:0] out_beats;

   int    checks = 0;
   int    failures = 0;
   string phase = "init";

   // Reference model state
   longint m_acc, m_od;
   int     m_cnt, m_ob;
   bit     m_first, m_ov, m_aovf, m_len;

   example_prod_accum #(
      .PROD_W(21), .ACC_W(32), .OUT_W(16), .SHIFT(8), .MAX_LEN(1024)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .prod_data  (prod_data),
      .prod_valid (prod_valid),
      .prod_last  (prod_last),
      .prod_ready (prod_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_beats  (out_beats),
      .acc_ovf    (acc_ovf),
      .len_err    (len_err)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s: got %0d expected %0d", phase, tag, obs, exp);
      end
   endtask

   function automatic longint rnd_sat(input longint s);
      longint r;
      r = (s + (64'sd1 <<< (DEF_SHIFT - 1))) >>> DEF_SHIFT;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   task automatic model_reset();
      m_acc = 0; m_cnt = 0; m_first = 1; m_ov = 0;
      m_od = 0; m_ob = 0; m_aovf = 0; m_len = 0;
   endtask

   task automatic check_outs();
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_beats", out_beats, m_ob);
      chk("acc_ovf", acc_ovf, m_aovf);
      chk("len_err", len_err, m_len);
   endtask

   // One clock: drive, check ready, advance the model, check registered outputs.
   task automatic cyc(input bit v, input bit l, input longint d, input bit ordy);
      bit     exp_rdy, take;
      longint s;
      int     n;
      prod_valid = v; prod_last = l; prod_data = prod_t'(d); out_ready = ordy;
      #1;
      exp_rdy = !l || !m_ov || ordy;
      chk("prod_ready", prod_ready, exp_rdy);
      take = v && exp_rdy;
      if (m_ov && ordy) m_ov = 0;
      if (take) begin
         s = (m_first ? 64'sd0 : m_acc) + d;
         if (s > AMAX) begin s = AMAX; m_aovf = 1; end
         else if (s < AMIN) begin s = AMIN; m_aovf = 1; end
         n = m_first ? 1 : m_cnt + 1;
         if (n > 1024) begin n = 1024; m_len = 1; end
         if (l) begin
            m_ov = 1; m_od = rnd_sat(s); m_ob = n; m_first = 1; m_cnt = 0;
         end else begin
            m_acc = s; m_cnt = n; m_first = 0;
         end
      end
      @(posedge ap_clk); #1;
      check_outs();
   endtask

   initial begin
      prod_valid = 0; prod_last = 0; prod_data = '0; out_ready = 0;
      model_reset();
      phase = "reset";
      #2;
      check_outs();
      chk("prod_ready", prod_ready, 1);
      repeat (2) @(posedge ap_clk);
      #3 ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      phase = "t1";
      cyc(1, 0, 256, 1);
      cyc(1, 0, 512, 1);
      cyc(1, 1, -128, 1);
      chk("data3", out_data, 3);
      chk("beats3", out_beats, 3);
      chk("vld", out_valid, 1);
      cyc(0, 0, 0, 1);
      chk("vld_drop", out_valid, 0);

      phase = "t2";
      repeat (7) cyc(1, 0, 1048575, 1);
      cyc(1, 1, 1048575, 1);
      chk("sat_hi", out_data, 32767);
      repeat (7) cyc(1, 0, -1048576, 1);
      cyc(1, 1, -1048576, 1);
      chk("sat_lo", out_data, -32768);
      chk("no_ovf", acc_ovf, 0);
      cyc(0, 0, 0, 1);

      phase = "t3";
      cyc(1, 0, 256, 0);
      cyc(1, 0, 512, 0);
      cyc(1, 1, -128, 0);
      cyc(1, 0, 100, 0);
      cyc(1, 0, 200, 0);
      repeat (3) cyc(1, 1, 300, 0);
      chk("held", out_data, 3);
      chk("stall", prod_ready, 0);
      cyc(1, 1, 300, 1);
      chk("b_data", out_data, 2);
      chk("b_beats", out_beats, 3);
      cyc(0, 0, 0, 1);

      phase = "t4";
      cyc(1, 1, 384, 1);
      chk("single_a", out_data, 2);
      cyc(1, 1, -384, 1);
      chk("single_b", out_data, -1);
      chk("no_bubble", out_valid, 1);
      cyc(0, 0, 0, 1);

      phase = "t5";
      repeat (1024) cyc(1, 0, 1, 1);
      chk("len_ok", len_err, 0);
      cyc(1, 0, 1, 1);
      chk("len_err", len_err, 1);
      cyc(1, 1, 0, 1);
      chk("long_beats", out_beats, 1024);
      chk("long_data", out_data, 4);
      cyc(0, 0, 0, 1);

      phase = "t6";
      cyc(1, 1, 256, 0);
      cyc(1, 0, 50, 0);
      prod_valid = 0; prod_last = 0;
      ap_rst_n = 1'b0;
      #1;
      model_reset();
      check_outs();
      #1 ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      cyc(1, 1, 256, 1);
      chk("post_rst", out_data, 1);
      cyc(0, 0, 0, 1);

      phase = "t7";
      repeat (2048) cyc(1, 0, 1048575, 1);
      chk("ovf_edge", acc_ovf, 0);
      cyc(1, 0, 1048575, 1);
      chk("ovf_set", acc_ovf, 1);
      cyc(1, 1, -1048576, 1);
      chk("ovf_out", out_data, 32767);
      cyc(0, 0, 0, 1);

      phase = "rand";
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             longint'($urandom_range(0, 2097151)) - 64'sd1048576,
             $urandom_range(0, 2) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
